// File: rtl/ps2_key_tx.sv
// ----------------------------------------------------------------------------
// ps2_key_tx
//
// PS/2 device-side keystroke transmitter. It takes one key request, either a
// digit (0-9) or a WASD direction in the decoder's encoding, and maps it to a
// scan-code-set-2 make code. It then sends that code as an 11-bit PS/2 frame:
// a start bit, eight data bits LSB first, odd parity and a stop bit. When
// SEND_BREAK is set, the break sequence (F0, code) follows, with an idle gap
// between the bytes.
//
// Parameters
//   CLK_DIV     system clocks per PS/2 clock half-period
//   GAP_CYCLES  idle-high cycles between the bytes of one keystroke
//   SEND_BREAK  1: make, F0, make   0: make only
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   num_valid     numbers carries a key request (wins over dir_valid)
//   numbers       digit code, 0-9 valid, anything else is dropped
//   dir_valid     directions carries a key request
//   directions    001=w 100=a 011=s 010=d, other codes are dropped
//   host_inhibit  host is holding the PS/2 clock low
//   ready         a key request can be accepted this cycle
//   busy          a keystroke is in progress
//   frame_done    one-cycle pulse after each byte's stop bit completes
//   ps2_clk_o     PS/2 clock, idle high (registered)
//   ps2_data_o    PS/2 data, idle high (registered)
// ----------------------------------------------------------------------------
module ps2_key_tx #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000,
  parameter bit SEND_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       num_valid,
  input  logic [4:0] numbers,
  input  logic       dir_valid,
  input  logic [2:0] directions,
  input  logic       host_inhibit,
  output logic       ready,
  output logic       busy,
  output logic       frame_done,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  // One timer serves both the half-bit period and the inter-byte gap.
  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  localparam logic [3:0] LAST_BIT  = 4'd10;  // stop bit
  localparam logic [3:0] LAST_ABORTABLE_BIT = 4'd9;  // parity bit
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT_HI,
    S_BIT_LO,
    S_GAP
  } state_t;

  state_t        state_q,      state_d;
  logic [TW-1:0] timer_q,      timer_d;
  logic [3:0]    bit_idx_q,    bit_idx_d;
  logic [1:0]    byte_idx_q,   byte_idx_d;
  logic [7:0]    code_q,       code_d;
  logic          busy_q,       busy_d;
  logic          frame_done_q, frame_done_d;
  logic          ps2_clk_q,    ps2_clk_d;
  logic          ps2_data_q,   ps2_data_d;

  logic       req_ok;
  logic [7:0] req_code;
  logic [7:0] cur_byte;
  logic       last_byte;
  logic [3:0] bit_idx_inc;

  // Line value for frame bit 'idx' of byte 'b':
  // 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
    logic v;
    v = 1'b1;
    if (idx == 4'd0) begin
      v = 1'b0;
    end else if (idx <= 4'd8) begin
      v = b[3'(idx - 4'd1)];
    end else if (idx == 4'd9) begin
      v = ~^b;
    end
    return v;
  endfunction

  // Request decode. num_valid has priority. A request whose selected code is
  // out of range leaves req_ok low, so it is consumed without any effect.
  always_comb begin
    req_ok   = 1'b1;
    req_code = 8'h00;
    if (num_valid) begin
      case (numbers)
        5'd0:    req_code = 8'h45;
        5'd1:    req_code = 8'h16;
        5'd2:    req_code = 8'h1E;
        5'd3:    req_code = 8'h26;
        5'd4:    req_code = 8'h25;
        5'd5:    req_code = 8'h2E;
        5'd6:    req_code = 8'h36;
        5'd7:    req_code = 8'h3D;
        5'd8:    req_code = 8'h3E;
        5'd9:    req_code = 8'h46;
        default: req_ok   = 1'b0;
      endcase
    end else if (dir_valid) begin
      case (directions)
        3'b001:  req_code = 8'h1D;  // w
        3'b100:  req_code = 8'h1C;  // a
        3'b011:  req_code = 8'h1B;  // s
        3'b010:  req_code = 8'h23;  // d
        default: req_ok   = 1'b0;
      endcase
    end else begin
      req_ok = 1'b0;
    end
  end

  // Byte 1 of a break keystroke is the F0 prefix; bytes 0 and 2 are the code.
  assign cur_byte    = (byte_idx_q == 2'd1) ? BREAK_PREFIX : code_q;
  assign last_byte   = !SEND_BREAK || (byte_idx_q == 2'd2);
  assign bit_idx_inc = bit_idx_q + 4'd1;

  assign ready = (state_q == S_IDLE) && !host_inhibit;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    code_d       = code_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    ps2_clk_d    = ps2_clk_q;
    ps2_data_d   = ps2_data_q;

    case (state_q)
      S_IDLE: begin
        // The start bit goes on the line in the very next cycle.
        if (ready && req_ok) begin
          state_d    = S_BIT_HI;
          timer_d    = '0;
          bit_idx_d  = 4'd0;
          byte_idx_d = 2'd0;
          code_d     = req_code;
          busy_d     = 1'b1;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
        end
      end

      S_BIT_HI: begin
        if (host_inhibit && (bit_idx_q <= LAST_ABORTABLE_BIT)) begin
          // Host took the bus: release both lines and restart this byte
          // from its start bit once the host lets go.
          state_d    = S_GAP;
          timer_d    = '0;
          bit_idx_d  = 4'd0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b1;
        end else if (timer_q == DIV_LAST) begin
          state_d   = S_BIT_LO;
          timer_d   = '0;
          ps2_clk_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_BIT_LO: begin
        if (timer_q == DIV_LAST) begin
          timer_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d    = 4'd0;
            ps2_clk_d    = 1'b1;
            ps2_data_d   = 1'b1;
            frame_done_d = 1'b1;
            if (last_byte) begin
              state_d    = S_IDLE;
              byte_idx_d = 2'd0;
              busy_d     = 1'b0;
            end else begin
              state_d    = S_GAP;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end else begin
            state_d    = S_BIT_HI;
            bit_idx_d  = bit_idx_inc;
            ps2_clk_d  = 1'b1;
            ps2_data_d = frame_bit(bit_idx_inc, cur_byte);
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_GAP: begin
        // An inhibiting host holds the gap timer at zero, so the full gap
        // always follows its release.
        if (host_inhibit) begin
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          state_d    = S_BIT_HI;
          timer_d    = '0;
          bit_idx_d  = 4'd0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= 4'd0;
      byte_idx_q   <= 2'd0;
      code_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      code_q       <= code_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ps2_clk_o  = ps2_clk_q;
  assign ps2_data_o = ps2_data_q;

endmodule

// File: tb/tb_ps2_key_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_tx
//
// Two transmitters share one stimulus: index 0 sends make/F0/make and index 1
// sends make only. A line-level monitor decodes every PS/2 frame at the
// falling edges of ps2_clk_o. It checks the start, parity and stop bits, and
// compares each byte with a queue of bytes predicted from the scan-code table.
// Timing (latency, frame length, gaps, busy/frame_done) is checked against
// cycle counts computed from CLK_DIV and GAP_CYCLES.
// ----------------------------------------------------------------------------
module tb_ps2_key_tx;

  localparam int D = 4;  // CLK_DIV
  localparam int G = 8;  // GAP_CYCLES

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       num_valid = 1'b0;
  logic [4:0] numbers = 5'd0;
  logic       dir_valid = 1'b0;
  logic [2:0] directions = 3'd0;
  logic       host_inhibit = 1'b0;

  logic ready_w [2];
  logic busy_w  [2];
  logic fd_w    [2];
  logic pclk_w  [2];
  logic pdat_w  [2];

  always #5 clk = ~clk;

  ps2_key_tx #(.CLK_DIV(D), .GAP_CYCLES(G), .SEND_BREAK(1'b1)) u_brk (
    .clk(clk), .reset_n(reset_n),
    .num_valid(num_valid), .numbers(numbers),
    .dir_valid(dir_valid), .directions(directions),
    .host_inhibit(host_inhibit),
    .ready(ready_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]),
    .ps2_clk_o(pclk_w[0]), .ps2_data_o(pdat_w[0])
  );

  ps2_key_tx #(.CLK_DIV(D), .GAP_CYCLES(G), .SEND_BREAK(1'b0)) u_mk (
    .clk(clk), .reset_n(reset_n),
    .num_valid(num_valid), .numbers(numbers),
    .dir_valid(dir_valid), .directions(directions),
    .host_inhibit(host_inhibit),
    .ready(ready_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]),
    .ps2_clk_o(pclk_w[1]), .ps2_data_o(pdat_w[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference scan-code table.
  logic [7:0] digit_code [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Code that a request should produce, or -1 when it is dropped.
  function automatic int key_code(input logic nv, input logic [4:0] num,
                                  input logic dv, input logic [2:0] dir);
    int r;
    r = -1;
    if (nv) begin
      if (num <= 5'd9) r = int'(digit_code[num]);
    end else if (dv) begin
      case (dir)
        3'b001:  r = 'h1D;
        3'b100:  r = 'h1C;
        3'b011:  r = 'h1B;
        3'b010:  r = 'h23;
        default: r = -1;
      endcase
    end
    return r;
  endfunction

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  // ---------------- line-level frame monitor ----------------
  int          high_run [2];
  int          nbits    [2];
  logic [10:0] shreg    [2];
  logic        prev_clk [2];
  int          aborts   [2] = '{0, 0};

  task automatic frame_check(input int k);
    logic [7:0] data;
    logic [7:0] e;
    data = shreg[k][8:1];
    chk($sformatf("dut%0d_start", k), 32'(shreg[k][0]), 32'd0);
    chk($sformatf("dut%0d_stop", k), 32'(shreg[k][10]), 32'd1);
    chk($sformatf("dut%0d_odd_parity", k), 32'(^shreg[k][9:1]), 32'd1);
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      // No byte was expected; 0x100 can never match a byte.
      chk($sformatf("dut%0d_extra_frame", k), 32'(data), 32'h100);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("dut%0d_byte", k), 32'(data), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        nbits[k]    = 0;
        high_run[k] = 0;
        prev_clk[k] = 1'b1;
      end else begin
        if (pclk_w[k]) begin
          high_run[k]++;
          // Inside a frame the clock is never high longer than a half period.
          if (high_run[k] > D && nbits[k] > 0) begin
            aborts[k]++;
            nbits[k] = 0;
          end
        end else begin
          high_run[k] = 0;
        end
        if (prev_clk[k] && !pclk_w[k]) begin
          shreg[k][nbits[k]] = pdat_w[k];
          nbits[k]++;
          if (nbits[k] == 11) begin
            frame_check(k);
            nbits[k] = 0;
          end
        end
        prev_clk[k] = pclk_w[k];
      end
    end
  end

  // ---------------- one keystroke request ----------------
  // Entered and left at 1 time unit after a rising clock edge.
  task automatic run_key(input logic nv, input logic [4:0] num, input logic dv,
                         input logic [2:0] dir, input int inh_at, input int inh_len);
    int code;
    int nbytes    [2];
    int first_fd  [2];
    int last_fd   [2];
    int n_fd      [2];
    int busy_drop [2];
    int first_fall[2];
    int ab0;
    int c;
    bit done;

    code = key_code(nv, num, dv, dir);
    nbytes[0] = (code < 0) ? 0 : 3;
    nbytes[1] = (code < 0) ? 0 : 1;
    if (code >= 0) begin
      exp_q0.push_back(8'(code));
      exp_q0.push_back(8'hF0);
      exp_q0.push_back(8'(code));
      exp_q1.push_back(8'(code));
    end
    ab0 = aborts[0];
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_ready_before", k), 32'(ready_w[k]), 32'd1);
      first_fd[k] = -1; last_fd[k] = -1; n_fd[k] = 0;
      busy_drop[k] = -1; first_fall[k] = -1;
    end

    num_valid = nv; numbers = num; dir_valid = dv; directions = dir;
    @(posedge clk); #1;
    num_valid = 1'b0; dir_valid = 1'b0;

    c = 1;
    done = 1'b0;
    while (!done && c <= 3000) begin
      for (int k = 0; k < 2; k++) begin
        if (fd_w[k]) begin
          n_fd[k]++;
          if (first_fd[k] < 0) first_fd[k] = c;
          last_fd[k] = c;
        end
        if (!busy_w[k] && busy_drop[k] < 0) busy_drop[k] = c;
        if (!pclk_w[k] && first_fall[k] < 0) first_fall[k] = c;
        if (c == 1) begin
          chk($sformatf("dut%0d_busy_c1", k), 32'(busy_w[k]), (code >= 0) ? 32'd1 : 32'd0);
          chk($sformatf("dut%0d_ready_c1", k), 32'(ready_w[k]), (code >= 0) ? 32'd0 : 32'd1);
          chk($sformatf("dut%0d_data_c1", k), 32'(pdat_w[k]), (code >= 0) ? 32'd0 : 32'd1);
          chk($sformatf("dut%0d_clk_c1", k), 32'(pclk_w[k]), 32'd1);
        end
      end
      if (inh_len > 0 && c == inh_at + 1) begin
        chk("inhibit_clk_high", 32'(pclk_w[0]), 32'd1);
        chk("inhibit_data_high", 32'(pdat_w[0]), 32'd1);
      end
      if (inh_len > 0 && c == inh_at) host_inhibit = 1'b1;
      if (inh_len > 0 && c == inh_at + inh_len) host_inhibit = 1'b0;
      done = (c >= 3 * D) && !busy_w[0] && !busy_w[1] && !host_inhibit;
      if (!done) begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("key_finished_in_budget", 32'(done), 32'd1);
    host_inhibit = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_frame_done_count", k), 32'(n_fd[k]), 32'(nbytes[k]));
      if (code >= 0) begin
        chk($sformatf("dut%0d_first_clk_fall", k), 32'(first_fall[k]), 32'(D + 1));
        chk($sformatf("dut%0d_first_frame_done", k), 32'(first_fd[k]), 32'(22 * D + 1));
        chk($sformatf("dut%0d_busy_drop_at_last_fd", k), 32'(busy_drop[k]), 32'(last_fd[k]));
        if (k == 1 || inh_len == 0)
          chk($sformatf("dut%0d_last_frame_done", k), 32'(last_fd[k]),
              32'(nbytes[k] * 22 * D + (nbytes[k] - 1) * G + 1));
      end else begin
        chk($sformatf("dut%0d_no_clock", k), 32'(first_fall[k]), 32'hFFFF_FFFF);
        chk($sformatf("dut%0d_busy_stays_low", k), 32'(busy_drop[k]), 32'd1);
      end
      chk($sformatf("dut%0d_ready_after", k), 32'(ready_w[k]), 32'd1);
    end
    chk("dut0_bytes_outstanding", 32'(exp_q0.size()), 32'd0);
    chk("dut1_bytes_outstanding", 32'(exp_q1.size()), 32'd0);
    chk("dut0_aborts", 32'(aborts[0] - ab0), (inh_len > 0) ? 32'd1 : 32'd0);
    $display("key nv=%0d num=%0d dv=%0d dir=%b code=%0h inhibit_at=%0d frames=%0d/%0d cycles=%0d",
             nv, num, dv, dir, (code < 0) ? 0 : code, inh_len > 0 ? inh_at : 0,
             n_fd[0], n_fd[1], c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       r_nv, r_dv;
    logic [4:0] r_num;
    logic [2:0] r_dir;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_rst_ready", k), 32'(ready_w[k]), 32'd1);
      chk($sformatf("dut%0d_rst_busy", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("dut%0d_rst_fd", k), 32'(fd_w[k]), 32'd0);
      chk($sformatf("dut%0d_rst_clk", k), 32'(pclk_w[k]), 32'd1);
      chk($sformatf("dut%0d_rst_data", k), 32'(pdat_w[k]), 32'd1);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Digit 5 (0x2E), direction d, priority, dropped codes.
    run_key(1'b1, 5'd5, 1'b0, 3'b000, 0, 0);
    run_key(1'b0, 5'd0, 1'b1, 3'b010, 0, 0);
    run_key(1'b1, 5'd7, 1'b1, 3'b001, 0, 0);
    run_key(1'b1, 5'd12, 1'b0, 3'b000, 0, 0);
    run_key(1'b0, 5'd0, 1'b1, 3'b111, 0, 0);
    run_key(1'b1, 5'd10, 1'b1, 3'b010, 0, 0);

    // Host inhibit while idle: no request is taken.
    host_inhibit = 1'b1;
    #1;
    chk("dut0_ready_inhibited", 32'(ready_w[0]), 32'd0);
    chk("dut1_ready_inhibited", 32'(ready_w[1]), 32'd0);
    num_valid = 1'b1; numbers = 5'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("dut0_busy_inhibited", 32'(busy_w[0]), 32'd0);
    chk("dut1_clk_inhibited", 32'(pclk_w[1]), 32'd1);
    num_valid = 1'b0;
    host_inhibit = 1'b0;
    @(posedge clk); #1;

    // Inhibit in bit 4 BIT_HI of the F0 byte (cycles 129..132), held 30 cycles.
    run_key(1'b0, 5'd0, 1'b1, 3'b010, 130, 30);

    // Asynchronous reset in the start bit's low half.
    num_valid = 1'b1; numbers = 5'd3;
    @(posedge clk); #1;
    num_valid = 1'b0;
    repeat (D + 1) @(posedge clk);
    #1;
    chk("dut0_clk_low_before_reset", 32'(pclk_w[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_async_rst_clk", k), 32'(pclk_w[k]), 32'd1);
      chk($sformatf("dut%0d_async_rst_data", k), 32'(pdat_w[k]), 32'd1);
      chk($sformatf("dut%0d_async_rst_busy", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("dut%0d_async_rst_ready", k), 32'(ready_w[k]), 32'd1);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_key(1'b1, 5'd9, 1'b0, 3'b000, 0, 0);

    // Randomized requests.
    for (int i = 0; i < 12; i++) begin
      r_nv  = 1'($urandom_range(0, 1));
      r_dv  = r_nv ? 1'($urandom_range(0, 1)) : 1'b1;
      r_num = 5'($urandom_range(0, 11));
      r_dir = 3'($urandom_range(0, 7));
      run_key(r_nv, r_num, r_dv, r_dir, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_tx.md
Name: ps2_key_tx

Overview:
- PS/2 device-side keystroke transmitter, used as a keyboard emulator and as a loopback source for the PS/2 frame decoder.
- Accepts a digit (0-9) or a WASD direction in the same encodings the decoder emits, and maps it to a scan-code-set-2 make code.
- Serialises each byte as an 11-bit PS/2 frame on ps2_clk_o/ps2_data_o, optionally followed by the break sequence (F0, code).

Parameters:
CLK_DIV, 2500, system clocks per PS/2 clock half-period (50 MHz -> 10 kHz)
GAP_CYCLES, 5000, idle-high cycles between consecutive bytes of one keystroke
SEND_BREAK, 1, 1: send make, F0, make; 0: send make only

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
num_valid  in  1  numbers holds a key to send
numbers  in  5  digit code, 0-9 valid
dir_valid  in  1  directions holds a key to send
directions  in  3  001=w 100=a 011=s 010=d
host_inhibit  in  1  host holding PS/2 clock low
ready  out  1  key request can be accepted this cycle
busy  out  1  keystroke in progress
frame_done  out  1  one-cycle pulse after each byte's stop bit completes
ps2_clk_o  out  1  PS/2 clock, idle high
ps2_data_o  out  1  PS/2 data, idle high

Behaviour:
- Reset (asynchronous, any state): state IDLE, ready=1, busy=0, frame_done=0, ps2_clk_o=1, ps2_data_o=1, counters cleared.
- Scan codes: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46; w=1D a=1C s=1B d=23 (hex).
- Accept: ready=1 only in IDLE with host_inhibit=0. A request is accepted on an edge where ready and (num_valid or dir_valid) are both 1.
  - num_valid has priority; a simultaneous dir_valid is ignored, not queued.
  - Out-of-range codes (numbers>9, directions 000/101/110/111) are accepted and dropped: no transmission, no busy, ready stays 1.
- Byte sequence: code, F0, code when SEND_BREAK=1; otherwise code only.
- Frame: bit0 start=0, bits1-8 data LSB first, bit9 odd parity (total ones in data+parity odd), bit10 stop=1.
- States: IDLE -> BIT_HI -> BIT_LO -> (next bit BIT_HI | GAP | IDLE).
  - BIT_HI: ps2_data_o = current bit, ps2_clk_o=1, CLK_DIV cycles.
  - BIT_LO: ps2_clk_o=0, data held, CLK_DIV cycles.
  - Data only changes at BIT_HI entry. Each bit slot is 2*CLK_DIV cycles; a frame is 22*CLK_DIV cycles.
- Latency: ps2_data_o=0 (start bit) in the first cycle after the accepting edge. The first ps2_clk_o falling edge occurs CLK_DIV cycles later.
- End of byte: after bit10 BIT_LO, ps2_clk_o=1, ps2_data_o=1, frame_done pulses for one cycle.
  - GAP lasts GAP_CYCLES with both lines high, then starts the next byte.
  - After the last byte, go to IDLE; busy drops in the same cycle frame_done pulses.
- busy=1 from the accepting edge until the last frame_done. ready=0 throughout.
- All outputs are registered; no combinational path from inputs to ps2_* outputs.
- Inhibit, idle: while host_inhibit=1, ready=0 and no transmission starts.
- Inhibit, mid-frame: host_inhibit=1 sampled during BIT_HI of bits 0-9 aborts the current byte.
  - Lines go high next cycle; enter GAP, extended until host_inhibit=0.
  - After release, the aborted byte is retransmitted from the start bit; completed bytes are not resent.
- Inhibit, late: host_inhibit=1 during bit10 or any BIT_LO is ignored for that byte, and is handled at the next BIT_HI or in GAP.
- Counters: timer sized for max(CLK_DIV, GAP_CYCLES); bit index 0..10; byte index 0..2. All counters clear on the transitions above.

Test Plan:
- CLK_DIV=4, GAP_CYCLES=8, SEND_BREAK=0, numbers=5 -> ps2_data_o sampled at each ps2_clk_o falling edge = 0,0,1,1,1,0,1,0,0,1,1 (0x2E, parity 1); frame_done pulse at cycle 89 after accept; ready returns 1.
- SEND_BREAK=1, directions=010 (d) -> three frames: 0x23 (data 1,1,0,0,0,1,0,0, parity 0), 0xF0 (parity 1), 0x23. Gaps are 8 cycles high; three frame_done pulses; busy high throughout.
- num_valid=1 numbers=7 and dir_valid=1 directions=001 on the same edge -> only 0x3D sent; w never appears.
- numbers=12 with num_valid=1 -> accepted, no clock edges, busy stays 0, ready stays 1.
- host_inhibit=1 during bit 4 BIT_HI of byte F0, released 30 cycles later -> lines high within 1 cycle, F0 frame restarts from start bit, then final 0x23 (or code) sent.
- reset_n low mid-BIT_LO -> ps2_clk_o=1, ps2_data_o=1, busy=0, ready=1 immediately (asynchronously); next request transmits normally.
